// File: rtl/keypad_scanner_if.sv
// Key-code stream between the keypad scanner and the code lock digit input.
interface keypad_scanner_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with sweep-level debounce and a
// small show-ahead FIFO delivering one key code per distinct press.
module keypad_scanner #(
  parameter int CLK_DIV    = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [3:0]        col_n,
  input  logic [3:0]        row_n,
  keypad_scanner_if.master  key,
  output logic              overflow,
  output logic              multi
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;

  logic [3:0]       sync1;
  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic [15:0]      snap;
  logic [15:0]      snap_next;
  logic             step;
  logic             sweep_done;
  logic             empty;
  logic             single;
  logic [3:0]       key_idx;

  state_t           state;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             push;

  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             full;
  logic             pop;
  logic             do_push;
  logic [3:0]       head_next;
  logic [3:0]       code_q;

  assign step       = (div == DIV_W'(CLK_DIV - 1));
  assign sweep_done = step && (col == 2'd3);
  assign cnt_inc    = cnt + 1'b1;

  // Two-flop synchronizer for the asynchronous row lines; idles high like the pull-ups.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      sync1    <= row_n;
      row_sync <= sync1;
    end
  end

  // Snapshot with the current column's rows merged in, so a sweep is classified on its final sample edge.
  always_comb begin
    snap_next = snap;
    if (step) begin
      for (int r = 0; r < 4; r++) begin
        snap_next[r*4 + int'(col)] = ~row_sync[r];
      end
    end
  end

  // Classify the completed sweep as empty, a single key, or a chord.
  always_comb begin
    key_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap_next[i]) key_idx = 4'(i);
    end
    empty  = (snap_next == 16'd0);
    single = !empty && ((snap_next & (snap_next - 16'd1)) == 16'd0);
  end

  // Scan divider and column rotation; the column moves on the same edge its rows are captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div   <= '0;
      col   <= 2'd0;
      col_n <= 4'b1110;
      snap  <= 16'd0;
    end else begin
      snap <= snap_next;
      if (step) begin
        div   <= '0;
        col   <= col + 2'd1;
        col_n <= {col_n[2:0], col_n[3]};
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // Debounce FSM stepped once per sweep; push is a one-cycle request carrying cand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cand  <= 4'd0;
      cnt   <= '0;
      push  <= 1'b0;
      multi <= 1'b0;
    end else begin
      push <= 1'b0;
      if (sweep_done) begin
        multi <= !empty && !single;
        case (state)
          IDLE: begin
            if (single) begin
              cand <= key_idx;
              cnt  <= CNT_W'(1);
              if (DEBOUNCE == 1) begin
                push  <= 1'b1;
                state <= PRESSED;
              end else begin
                state <= CAND;
              end
            end
          end
          CAND: begin
            if (single && (key_idx == cand)) begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                push  <= 1'b1;
                state <= PRESSED;
              end
            end else if (single) begin
              cand <= key_idx;
              cnt  <= CNT_W'(1);
            end else begin
              state <= IDLE;
            end
          end
          PRESSED: begin
            if (empty) begin
              cnt   <= CNT_W'(1);
              state <= (DEBOUNCE == 1) ? IDLE : REL;
            end
          end
          REL: begin
            if (empty) begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_W'(DEBOUNCE)) state <= IDLE;
            end else begin
              state <= PRESSED;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign pop        = key.key_valid && key.key_ready;
  assign full       = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign do_push    = push && (!full || pop);
  assign rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
  assign count_next = count + (PTR_W+1)'(do_push) - (PTR_W+1)'(pop);
  assign head_next  = (do_push && (rd_next == wr_ptr)) ? cand : mem[rd_next];

  // FIFO storage; key_code is a register loaded with the upcoming head so it holds when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 4'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      code_q   <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= cand;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_next;
      count  <= count_next;
      if (count_next != '0) code_q <= head_next;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign key.key_valid = (count != '0);
  assign key.key_code  = code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model shorts pressed keys'
// rows to the driven column, expected codes are queued as presses are driven.
module tb_keypad_scanner;

  localparam int CLK_DIV    = 4;
  localparam int DEBOUNCE   = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int SWEEP      = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic        overflow;
  logic        multi;
  logic [15:0] keys;
  logic [3:0]  exp_q [$];
  int          tests_run = 0;
  int          tests_failed = 0;

  keypad_scanner_if key_if ();

  keypad_scanner #(
    .CLK_DIV    (CLK_DIV),
    .DEBOUNCE   (DEBOUNCE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_n    (col_n),
    .row_n    (row_n),
    .key      (key_if),
    .overflow (overflow),
    .multi    (multi)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] k, input int sweeps);
    keys = k;
    waitCycles(sweeps * SWEEP);
  endtask

  function automatic logic [15:0] keyMask(input int n);
    logic [15:0] one;
    one = 16'd1;
    return one << n;
  endfunction

  // Consumer side of the stream: every accepted code is popped from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (key_if.key_valid && key_if.key_ready) begin
        if (exp_q.size() == 0) checkOutput("spurious_valid", 16'(key_if.key_valid), 16'd0);
        else checkOutput("key_code", 16'(key_if.key_code), 16'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [3:0] col_exp;
    logic [3:0] one4;
    int         ovf_keys [5];
    ovf_keys = '{1, 2, 3, 4, 6};
    one4 = 4'd1;

    rst = 1'b1;
    keys = 16'd0;
    key_if.key_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_col_n", 16'(col_n), 16'hE);
    checkOutput("rst_valid", 16'(key_if.key_valid), 16'd0);
    checkOutput("rst_code", 16'(key_if.key_code), 16'd0);
    checkOutput("rst_overflow", 16'(overflow), 16'd0);
    checkOutput("rst_multi", 16'(multi), 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      col_exp = ~(one4 << (i % 4));
      checkOutput("col_rotate", 16'(col_n), 16'(col_exp));
      waitCycles(CLK_DIV);
    end

    $display("[TB] clean press");
    exp_q.push_back(4'd5);
    applyStimulus(keyMask(5), 3);
    checkOutput("press_early", 16'(key_if.key_valid), 16'd0);
    waitCycles(1);
    checkOutput("press_valid", 16'(key_if.key_valid), 16'd1);
    checkOutput("press_code", 16'(key_if.key_code), 16'd5);
    waitCycles(SWEEP - 1);
    applyStimulus(keyMask(5), 2);
    applyStimulus(16'd0, 3);
    checkOutput("clean_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] bounce");
    applyStimulus(keyMask(9), 2);
    applyStimulus(16'd0, 1);
    applyStimulus(keyMask(9), 2);
    applyStimulus(16'd0, 1);
    checkOutput("bounce_quiet", 16'(key_if.key_valid), 16'd0);
    exp_q.push_back(4'd9);
    applyStimulus(keyMask(9), 3);
    applyStimulus(16'd0, 3);
    checkOutput("bounce_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] held key");
    exp_q.push_back(4'd15);
    applyStimulus(keyMask(15), 20);
    applyStimulus(16'd0, 4);
    exp_q.push_back(4'd15);
    applyStimulus(keyMask(15), 3);
    applyStimulus(16'd0, 3);
    checkOutput("held_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] overflow");
    key_if.key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < FIFO_DEPTH) exp_q.push_back(4'(ovf_keys[i]));
      applyStimulus(keyMask(ovf_keys[i]), 3);
      applyStimulus(16'd0, 3);
      if (i == 3) checkOutput("ovf_not_yet", 16'(overflow), 16'd0);
    end
    checkOutput("ovf_set", 16'(overflow), 16'd1);
    checkOutput("ovf_head", 16'(key_if.key_code), 16'd1);
    key_if.key_ready = 1'b1;
    waitCycles(FIFO_DEPTH);
    checkOutput("ovf_empty", 16'(key_if.key_valid), 16'd0);
    checkOutput("ovf_sticky", 16'(overflow), 16'd1);
    checkOutput("ovf_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] chord");
    applyStimulus(keyMask(1) | keyMask(2), 1);
    checkOutput("chord_multi", 16'(multi), 16'd1);
    applyStimulus(keyMask(1) | keyMask(2), 4);
    checkOutput("chord_multi_hold", 16'(multi), 16'd1);
    checkOutput("chord_no_code", 16'(key_if.key_valid), 16'd0);
    exp_q.push_back(4'd1);
    applyStimulus(keyMask(1), 1);
    checkOutput("chord_multi_clear", 16'(multi), 16'd0);
    applyStimulus(keyMask(1), 2);
    applyStimulus(16'd0, 3);
    checkOutput("chord_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] reset mid-press");
    applyStimulus(keyMask(7), 2);
    waitCycles(5);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_col_n", 16'(col_n), 16'hE);
    checkOutput("mid_rst_valid", 16'(key_if.key_valid), 16'd0);
    checkOutput("mid_rst_code", 16'(key_if.key_code), 16'd0);
    checkOutput("mid_rst_overflow", 16'(overflow), 16'd0);
    checkOutput("mid_rst_multi", 16'(multi), 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(4'd7);
    applyStimulus(keyMask(7), 3);
    checkOutput("redetect_early", 16'(key_if.key_valid), 16'd0);
    waitCycles(1);
    checkOutput("redetect_valid", 16'(key_if.key_valid), 16'd1);
    checkOutput("redetect_code", 16'(key_if.key_code), 16'd7);
    applyStimulus(16'd0, 2);
    checkOutput("final_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
